cineraria_core_led_pwm: RTL and testbench
=========================================

# cineraria_core_led_pwm

Parametrised Avalon-MM output port for LED banks: a WIDTH-bit data register with atomic set/clear/toggle, per-bit hardware blink and a global PWM brightness engine. It sits on the same slave bus as the existing single-register PIO and drives board LEDs directly. Software loads a blink or brightness pattern once and the hardware keeps running it with no CPU involvement.

## Interface
- WIDTH, 10: output channel count, 1..32.
- PWM_BITS, 8: PWM resolution, 1..16.
- PRESCALE, 50000: clk cycles per blink tick, >= 2.
- RESET_VALUE, 0: DATA register value after reset, WIDTH bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data. Bits above a register's width are ignored.
- readdata  out  32  combinational read data, zero-extended.
- out_port  out  WIDTH  registered LED drive.

## Operation
- A write occurs when chipselect=1 and write_n=0. Reads have zero wait states. Unused bits and unmapped addresses read 0.
- Register map (word address):
  - 0 DATA: R/W, WIDTH bits.
  - 1 SET: a write ORs into DATA. Reads return DATA.
  - 2 CLR: a write ANDs ~writedata into DATA. Reads return DATA.
  - 3 TGL: a write XORs into DATA. Reads return DATA.
  - 4 BLINK_EN: R/W, WIDTH bits. A 1 bit gates that channel with the blink phase.
  - 5 BLINK_HALF: R/W, 16 bits. Half-period in ticks.
  - 6 DUTY: R/W, PWM_BITS bits.
  - 7 CTRL: R/W bit0 PWM_EN. Read-only bit1 PHASE, bit2 TICK_PENDING (always 0, reserved).
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 for one cycle when the count equals PRESCALE-1.
- Blink:
  - A 16-bit counter increments on each tick.
  - When counter = BLINK_HALF-1, the counter clears and PHASE inverts.
  - BLINK_HALF=0: PHASE is forced to 1 and the counter is held at 0.
  - Any write to BLINK_HALF clears the blink counter and the prescaler and sets PHASE=1.
- PWM:
  - A free-running PWM_BITS counter increments every clk and wraps.
  - pwm_on = (cnt < DUTY) or (DUTY = all ones).
  - With PWM_EN=0, pwm_on=1.
  - DUTY=0 with PWM_EN=1 means fully off.
- Output: next_out[i] = DATA[i] & (~BLINK_EN[i] | PHASE) & pwm_on. out_port registers next_out.
- Reset values:
  - DATA=RESET_VALUE, BLINK_EN=0, BLINK_HALF=0, DUTY=all ones, PWM_EN=0, PHASE=1.
  - All counters 0.
  - out_port=RESET_VALUE.
- Asserting reset mid-blink or mid-PWM returns every register and counter to its reset value immediately and asynchronously.

## Timing
- A register write at clk edge N is visible on readdata from edge N. The corresponding out_port change appears at edge N+1.
- SET/CLR/TGL are read-modify-write in one cycle. Back-to-back writes on consecutive cycles all take effect; none is lost.
- Blink period = 2·BLINK_HALF·PRESCALE clk cycles.
- The first PHASE inversion after a BLINK_HALF write occurs BLINK_HALF·PRESCALE cycles after the write edge. out_port follows one cycle later.
- PWM period = 2^PWM_BITS clk cycles. High time = DUTY cycles per period, or the full period when DUTY is all ones.
- A DUTY change takes effect on the next compare, not on a period boundary. Glitch-free period alignment is not required.
- A write and a tick or phase inversion in the same cycle: the register write lands, and the counter advances per the rules above. The exception is a BLINK_HALF write, whose clear takes priority.

## Test plan
Bench parameters: WIDTH=10, PWM_BITS=4, PRESCALE=4.
- Reset: hold reset_n=0, then release. Expect out_port=0x000, readdata@0=0, readdata@6=0xF, readdata@7=0x2.
- Atomic ops:
  - Write DATA=0x0F0, then SET 0x003 on consecutive cycles. Expect DATA=0x0F3.
  - CLR 0x030. Expect 0x0C3.
  - TGL 0x3FF. Expect 0x33C.
  - out_port tracks each result one cycle after the write.
- Blink: DATA=0x3FF, BLINK_EN=0x001, BLINK_HALF=2.
  - out_port[0] is high for 8 cycles then low for 8 cycles, repeating.
  - Bits 9:1 stay high.
  - CTRL bit1 mirrors the phase.
- PWM: DATA=0x001, PWM_EN=1.
  - DUTY=5: out_port[0] is high for 5 of every 16 cycles.
  - DUTY=0: constantly 0.
  - DUTY=15: constantly 1.
- Blink restart: write BLINK_HALF=3 mid-period. PHASE is forced to 1, and the next inversion lands exactly 12 cycles after the write.
- Reset mid-operation: assert reset_n during active blink+PWM. out_port is 0x000 asynchronously. After release all registers hold their reset values and PHASE=1.

Source files
------------

// File: rtl/cineraria_core_led_pwm.sv
`default_nettype none
// ============================================================================
// Module      : cineraria_core_led_pwm
// Description : Avalon-MM LED output port. WIDTH-bit DATA register with
//               atomic set/clear/toggle aliases, per-channel hardware blink
//               gated by a shared blink phase, and a global PWM brightness
//               engine. Once loaded, patterns run with no CPU involvement.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               address    - register word select (0..7)
//               chipselect - slave select
//               write_n    - active-low write strobe
//               writedata  - write data, bits above a register's width ignored
//               readdata   - combinational read data, zero-extended
//               out_port   - registered LED drive
// Revision    : 1.0 - initial release
// ============================================================================
module cineraria_core_led_pwm #(
  parameter int                WIDTH       = 10,
  parameter int                PWM_BITS    = 8,
  parameter int                PRESCALE    = 50000,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLR   = 3'd2;
  localparam logic [2:0] ADDR_TGL   = 3'd3;
  localparam logic [2:0] ADDR_BEN   = 3'd4;
  localparam logic [2:0] ADDR_HALF  = 3'd5;
  localparam logic [2:0] ADDR_DUTY  = 3'd6;
  localparam logic [2:0] ADDR_CTRL  = 3'd7;

  logic [WIDTH-1:0]     data;
  logic [WIDTH-1:0]     blink_en;
  logic [15:0]          blink_half;
  logic [PWM_BITS-1:0]  duty;
  logic                 pwm_en;
  logic                 phase;
  logic [PRE_W-1:0]     pre_cnt;
  logic [15:0]          blink_cnt;
  logic [PWM_BITS-1:0]  pwm_cnt;

  logic                 wr;
  logic                 wr_half;
  logic                 tick;
  logic                 pwm_on;
  logic [WIDTH-1:0]     next_out;

  // Upper writedata bits are don't-care for narrow registers.
  logic                 unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr       = chipselect & ~write_n;
  assign wr_half  = wr && (address == ADDR_HALF);
  assign tick     = (pre_cnt == PRE_LAST);

  // All-ones duty means fully on; otherwise high while the counter is below duty.
  assign pwm_on   = ~pwm_en | (&duty) | (pwm_cnt < duty);
  assign next_out = data & (~blink_en | {WIDTH{phase}}) & {WIDTH{pwm_on}};

  // Register file; SET/CLR/TGL are single-cycle read-modify-write on DATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data       <= RESET_VALUE;
      blink_en   <= '0;
      blink_half <= '0;
      duty       <= '1;
      pwm_en     <= 1'b0;
    end else if (wr) begin
      case (address)
        ADDR_DATA: data       <= writedata[WIDTH-1:0];
        ADDR_SET:  data       <= data | writedata[WIDTH-1:0];
        ADDR_CLR:  data       <= data & ~writedata[WIDTH-1:0];
        ADDR_TGL:  data       <= data ^ writedata[WIDTH-1:0];
        ADDR_BEN:  blink_en   <= writedata[WIDTH-1:0];
        ADDR_HALF: blink_half <= writedata[15:0];
        ADDR_DUTY: duty       <= writedata[PWM_BITS-1:0];
        default:   pwm_en     <= writedata[0];
      endcase
    end
  end

  // Prescaler and blink phase. A BLINK_HALF write restarts the whole
  // timebase so the first inversion lands exactly BLINK_HALF ticks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      if (wr_half || tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      if (wr_half || (blink_half == 16'd0)) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (tick) begin
        if (blink_cnt == (blink_half - 16'd1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

  // Free-running PWM counter and registered LED drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      out_port <= RESET_VALUE;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      out_port <= next_out;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLR, ADDR_TGL: readdata[WIDTH-1:0] = data;
      ADDR_BEN:  readdata[WIDTH-1:0]    = blink_en;
      ADDR_HALF: readdata[15:0]         = blink_half;
      ADDR_DUTY: readdata[PWM_BITS-1:0] = duty;
      ADDR_CTRL: readdata[2:0]          = {1'b0, phase, pwm_en};
      default:   readdata               = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cineraria_core_led_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cineraria_core_led_pwm
// Description : Scoreboard bench for cineraria_core_led_pwm. A reference model
//               derives LED drive from elapsed cycle counts (PWM position and
//               blink phase as arithmetic on time since the last restart) and
//               queues expected out_port / readdata; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cineraria_core_led_pwm;

  localparam int         WIDTH    = 10;
  localparam int         PWM_BITS = 4;
  localparam int         PRESCALE = 4;
  localparam int         PWM_PER  = 1 << PWM_BITS;
  localparam logic [9:0] ALL      = 10'h3FF;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  cineraria_core_led_pwm #(
    .WIDTH(WIDTH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE), .RESET_VALUE(10'h000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        rd_strobe = 1'b0;
  logic [9:0]  out_q[$];
  logic [31:0] rd_q[$];

  // Reference model state: register contents plus time bookkeeping.
  logic [9:0]  m_data   = 10'h000;
  logic [9:0]  m_en     = 10'h000;
  int          m_half   = 0;
  int          m_duty   = PWM_PER - 1;
  bit          m_pwm_en = 1'b0;
  int          m_t0     = 0;   // edge index of last blink restart
  int          m_e      = 0;   // posedges since reset release

  function automatic bit ref_phase(int e);
    if (m_half == 0) return 1'b1;
    return (((e - m_t0) / (m_half * PRESCALE)) % 2) == 0;
  endfunction

  function automatic bit ref_pwm_on(int e);
    if (!m_pwm_en) return 1'b1;
    if (m_duty == PWM_PER - 1) return 1'b1;
    return (e % PWM_PER) < m_duty;
  endfunction

  function automatic logic [31:0] ref_read(logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return {22'd0, m_data};
      3'd4:    return {22'd0, m_en};
      3'd5:    return 32'(m_half);
      3'd6:    return 32'(m_duty);
      default: return {30'd0, ref_phase(m_e), m_pwm_en};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: predict out_port for this edge from pre-edge state, then apply writes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data   <= 10'h000;
      m_en     <= 10'h000;
      m_half   <= 0;
      m_duty   <= PWM_PER - 1;
      m_pwm_en <= 1'b0;
      m_t0     <= 0;
      m_e      <= 0;
      out_q.delete();
    end else begin
      out_q.push_back(m_data & (~m_en | (ref_phase(m_e) ? ALL : 10'h000))
                             & (ref_pwm_on(m_e) ? ALL : 10'h000));
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[9:0];
          3'd1: m_data <= m_data | writedata[9:0];
          3'd2: m_data <= m_data & ~writedata[9:0];
          3'd3: m_data <= m_data ^ writedata[9:0];
          3'd4: m_en   <= writedata[9:0];
          3'd5: begin
            m_half <= int'(writedata[15:0]);
            m_t0   <= m_e + 1;
          end
          3'd6: m_duty <= int'(writedata[3:0]);
          default: m_pwm_en <= writedata[0];
        endcase
      end
      m_e <= m_e + 1;
    end
  end

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (out_q.size() > 0) check("out_port", {22'd0, out_port}, {22'd0, out_q.pop_front()});
      if (rd_strobe) begin
        if (rd_q.size() > 0) check("readdata", readdata, rd_q.pop_front());
        else check("readdata_queue_empty", 32'd1, 32'd0);
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d; rd_strobe = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a; writedata = 32'd0;
    rd_q.push_back(ref_read(a));
    rd_strobe = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; rd_strobe = 1'b0;
    end
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("out_in_reset", {22'd0, out_port}, 32'h000);
    reset_n = 1'b1;
    bus_read(3'd0); bus_read(3'd6); bus_read(3'd7); bus_read(3'd4); bus_read(3'd5);
    idle(2);

    // Atomic ops, back-to-back
    bus_write(3'd0, 32'h0F0); bus_write(3'd1, 32'h003); bus_read(3'd0);
    bus_write(3'd2, 32'h030); bus_read(3'd2);
    bus_write(3'd3, 32'h3FF); bus_read(3'd3);
    bus_write(3'd3, 32'hFFFF_FC00); bus_read(3'd0);
    idle(3);

    // Blink
    bus_write(3'd0, 32'h3FF); bus_write(3'd4, 32'h001); bus_write(3'd5, 32'd2);
    for (int i = 0; i < 12; i++) begin bus_read(3'd7); idle(2); end

    // PWM
    bus_write(3'd4, 32'h000); bus_write(3'd0, 32'h001); bus_write(3'd7, 32'h1);
    bus_write(3'd6, 32'd5);  idle(40); bus_read(3'd6);
    bus_write(3'd6, 32'd0);  idle(20);
    bus_write(3'd6, 32'd15); idle(20); bus_read(3'd7);

    // Blink restart mid-period
    bus_write(3'd7, 32'h0); bus_write(3'd0, 32'h3FF); bus_write(3'd4, 32'h201);
    bus_write(3'd5, 32'd2); idle(11);
    bus_write(3'd5, 32'd3);
    for (int i = 0; i < 30; i++) bus_read(3'd7);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [2:0]  a;
      r = $urandom_range(0, 3);
      a = 3'($urandom_range(0, 7));
      if (r == 0) idle(1);
      else if (r == 1) bus_read(a);
      else if (a == 3'd5) begin
        if ($urandom_range(0, 3) == 0) bus_write(a, $urandom_range(0, 4));
        else idle(1);
      end
      else if (a == 3'd7) bus_write(a, $urandom_range(0, 1));
      else bus_write(a, $urandom());
    end

    // Reset mid-operation
    bus_write(3'd0, 32'h3FF); bus_write(3'd4, 32'h0FF); bus_write(3'd5, 32'd2);
    bus_write(3'd6, 32'd9);   bus_write(3'd7, 32'h1);
    idle(13);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_out", {22'd0, out_port}, 32'h000);
    idle(2);
    check("out_held_reset", {22'd0, out_port}, 32'h000);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) bus_read(3'(a));
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
